i2s_tx: RTL and testbench

- I2S serializer. Sits directly downstream of the I2S clock generator and shares its MCLK domain.
- Accepts stereo sample pairs over a valid/ready handshake and buffers one pair.
- Shifts each word out MSB-first on sdata, aligned to the generator's sclk/lrclk using standard I2S one-bit delay.
- Slot bits beyond DW are zero-padded. Underruns output silence and are counted.

---
 rtl/i2s_tx.sv | 87 ++++++++
 tb/tb_i2s_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: I2S serializer with a one-pair holding buffer, one-bit-delay framing and underrun counting.
module i2s_tx #(
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sclk,
   input  logic          lrclk,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_left,
   input  logic [DW-1:0] in_right,
   output logic          sdata,
   output logic          underrun,
   output logic [15:0]   underrun_count
);
   localparam int CW = $clog2(DW + 1);
   logic            sclk_q, lrclk_q, buf_full_q, buf_full_d, sdata_q, sdata_d, ur_q, ur_d;
   logic [2*DW-1:0] buf_q, buf_d, act_q, act_d;
   logic [DW-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [15:0]     ucnt_q, ucnt_d;
   logic            sclk_fall, lr_edge;
   always_comb begin
      sclk_fall  = sclk_q & ~sclk;
      lr_edge    = lrclk != lrclk_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      act_d      = act_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      sdata_d    = sdata_q;
      ur_d       = 1'b0;
      ucnt_d     = ucnt_q;
      if (in_valid && !buf_full_q) begin
         buf_d      = {in_left, in_right};
         buf_full_d = 1'b1;
      end
      // Slot starts take priority over a coincident sclk fall: that fall is the delay bit.
      if (lr_edge && !lrclk) begin
         act_d      = buf_full_q ? buf_q : '0;
         buf_full_d = buf_full_q ? 1'b0 : buf_full_d;
         ur_d       = !buf_full_q;
         ucnt_d     = (!buf_full_q && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
         shreg_d    = act_d[2*DW-1:DW];
         bit_cnt_d  = CW'(DW);
         sdata_d    = 1'b0;
      end else if (lr_edge) begin
         shreg_d   = act_q[DW-1:0];
         bit_cnt_d = CW'(DW);
         sdata_d   = 1'b0;
      end else if (sclk_fall) begin
         sdata_d   = (bit_cnt_q != '0) & shreg_q[DW-1];
         shreg_d   = (bit_cnt_q != '0) ? shreg_q << 1 : shreg_q;
         bit_cnt_d = (bit_cnt_q != '0) ? bit_cnt_q - 1'b1 : bit_cnt_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q     <= 1'b0;
         lrclk_q    <= 1'b1;
         buf_full_q <= 1'b0;
         buf_q      <= '0;
         act_q      <= '0;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         sdata_q    <= 1'b0;
         ur_q       <= 1'b0;
         ucnt_q     <= '0;
      end else begin
         sclk_q     <= sclk;
         lrclk_q    <= lrclk;
         buf_full_q <= buf_full_d;
         buf_q      <= buf_d;
         act_q      <= act_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         sdata_q    <= sdata_d;
         ur_q       <= ur_d;
         ucnt_q     <= ucnt_d;
      end
   end
   assign in_ready       = ~buf_full_q;
   assign sdata          = sdata_q;
   assign underrun       = ur_q;
   assign underrun_count = ucnt_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: drives a 256-clk-per-frame generator and checks against a slot-level model of the I2S stream.
module tb_i2s_tx;
   localparam int DW = 24;
   logic          clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, lrclk = 1'b1, in_valid = 1'b0;
   logic [DW-1:0] in_left = '0, in_right = '0;
   logic          in_ready, sdata, underrun;
   logic [15:0]   underrun_count;
   logic [7:0]    cnt = '0;
   int            mode = 0, pass_n = 0, total_n = 0;
   logic [DW-1:0] q_l[$], q_r[$];
   logic [DW-1:0] cur_l = '0, cur_r = '0;
   logic [15:0]   m_cnt = '0;
   logic          ur_exp = 1'b0;

   i2s_tx #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .lrclk(lrclk),
      .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
      .sdata(sdata), .underrun(underrun), .underrun_count(underrun_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      else pass_n++;
   endtask

   function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
      return (k >= 1 && k <= DW) ? w[DW-k] : 1'b0;
   endfunction

   // Generator: sclk = 4 clk period, 32 sclk per slot, lrclk and sclk fall together at slot edges.
   task automatic tick();
      logic hs;
      hs = in_valid && in_ready && rst_n;
      @(posedge clk);
      #1;
      cnt   = rst_n ? cnt + 8'd1 : 8'd0;
      sclk  = cnt[1];
      lrclk = ~cnt[7];
      case (mode)
         1: begin
            in_valid = 1'b1;
            if (hs) begin
               in_left  = in_left + 1'b1;
               in_right = in_right + 1'b1;
            end
         end
         2: begin
            in_valid = 1'($urandom_range(0, 1));
            in_left  = DW'($urandom);
            in_right = DW'($urandom);
         end
         3: begin
            in_valid = !hs;
            if (hs) mode = 0;
         end
         default: in_valid = 1'b0;
      endcase
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial forever begin
      logic ready_m;
      @(negedge clk);
      if (!rst_n) begin
         q_l.delete();
         q_r.delete();
         cur_l  = '0;
         cur_r  = '0;
         m_cnt  = '0;
         ur_exp = 1'b0;
         check("rst_sdata", sdata, 0);
         check("rst_ready", in_ready, 1);
         check("rst_underrun", underrun, 0);
         check("rst_count", underrun_count, 0);
      end else begin
         ready_m = q_l.size() == 0;
         check("in_ready", in_ready, ready_m);
         check("underrun", underrun, ur_exp);
         check("underrun_count", underrun_count, m_cnt);
         if (cnt[1:0] == 2'd2)
            check(lrclk ? "sdata_right" : "sdata_left", sdata, exp_bit(lrclk ? cur_r : cur_l, int'(cnt[6:2])));
         ur_exp = 1'b0;
         if (cnt == 8'd128) begin
            if (q_l.size() > 0) begin
               cur_l = q_l.pop_front();
               cur_r = q_r.pop_front();
            end else begin
               cur_l  = '0;
               cur_r  = '0;
               ur_exp = 1'b1;
               if (m_cnt != 16'hFFFF) m_cnt++;
            end
         end
         if (in_valid && ready_m) begin
            q_l.push_back(in_left);
            q_r.push_back(in_right);
         end
      end
   end

   initial begin
      reset_pulse();
      in_left  = 24'hA5F00F;
      in_right = 24'h123456;
      mode     = 3;
      repeat (512) tick();
      reset_pulse();
      repeat (3 * 256) tick();
      in_left  = DW'($urandom);
      in_right = DW'($urandom);
      mode     = 1;
      repeat (4 * 256) tick();
      mode = 0;
      repeat (256) tick();
      in_left  = 24'h800001;
      in_right = DW'($urandom);
      mode     = 3;
      repeat (512) tick();
      reset_pulse();
      repeat (5) tick();
      force dut.ucnt_q = 16'hFFFE;
      m_cnt = 16'hFFFE;
      tick();
      release dut.ucnt_q;
      repeat (3 * 256) tick();
      mode = 2;
      repeat (3 * 256) tick();
      while (cnt != 8'd169) tick();
      rst_n = 1'b0;
      mode  = 0;
      #1;
      check("async_rst_sdata", sdata, 0);
      check("async_rst_ready", in_ready, 1);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (256) tick();
      in_left  = DW'($urandom);
      in_right = DW'($urandom);
      mode     = 3;
      repeat (512) tick();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
